// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Results are computed when an operation is accepted and held until the latency expires.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [31:0]   ph;
  logic [31:0]   pl;
  logic          pwr;

  logic [63:0] mul_s;
  logic [63:0] mul_u;
  logic        div_signed;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] quo;
  logic [31:0] rem;

  // Lower 64 bits of the product of sign-extended operands equal the signed product.
  assign mul_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign mul_u = {32'd0, A} * {32'd0, B};

  // One unsigned divider serves both DIV and DIVU; signed division works on magnitudes,
  // which also yields 0x80000000 / -1 = 0x80000000 with remainder 0 without overflow.
  always_comb begin
    div_signed = (MDOp == OP_DIV);
    a_mag      = A[31] ? (~A + 32'd1) : A;
    b_mag      = B[31] ? (~B + 32'd1) : B;
    dvd        = div_signed ? a_mag : A;
    dvs        = div_signed ? b_mag : B;
    if (dvs == 32'd0) begin
      dvs = 32'd1;
    end
    uq  = dvd / dvs;
    ur  = dvd % dvs;
    quo = uq;
    rem = ur;
    if (div_signed) begin
      quo = (A[31] ^ B[31]) ? (~uq + 32'd1) : uq;
      rem = A[31] ? (~ur + 32'd1) : ur;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      ph    <= '0;
      pl    <= '0;
      pwr   <= 1'b0;
      Busy  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            case (MDOp)
              OP_MULT, OP_MULTU: begin
                {ph, pl} <= (MDOp == OP_MULT) ? mul_s : mul_u;
                pwr      <= 1'b1;
                count    <= MULT_LOAD;
                Busy     <= 1'b1;
                state    <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                ph    <= rem;
                pl    <= quo;
                // Divide by zero still occupies the unit but leaves HI/LO untouched.
                pwr   <= (B != 32'd0);
                count <= DIV_LOAD;
                Busy  <= 1'b1;
                state <= RUN;
              end
              OP_MTHI: HI <= A;
              OP_MTLO: LO <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            if (pwr) begin
              HI <= ph;
              LO <= pl;
            end
            pwr   <= 1'b0;
            Busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases with literal expectations plus
// randomized traffic compared every cycle against a cycle-stamped behavioural model.
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  MDOp;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  always #5 clk = ~clk;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDOp(MDOp),
    .Start(Start), .Busy(Busy), .HI(HI), .LO(LO)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // Model: an operation accepted at edge number c finishes at edge c+N; the unit is
  // busy whenever the edge count is below that finish stamp.
  longint      m_cycle   = 0;
  longint      m_done_at = 0;
  logic [31:0] m_hi = '0, m_lo = '0, m_ph = '0, m_pl = '0;
  bit          m_wr = 1'b0;
  bit          mon_on = 1'b0;

  task automatic model_edge(bit st, logic [2:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] p;
    longint q, r;
    m_cycle++;
    if (m_cycle - 1 < m_done_at) begin
      if (m_cycle == m_done_at && m_wr) begin
        m_hi = m_ph;
        m_lo = m_pl;
      end
    end else if (st) begin
      case (op)
        3'd0, 3'd1: begin
          if (op == 3'd0) p = 64'(longint'(int'(a)) * longint'(int'(b)));
          else            p = 64'(a) * 64'(b);
          m_ph = p[63:32]; m_pl = p[31:0]; m_wr = 1'b1;
          m_done_at = m_cycle + MC;
        end
        3'd2, 3'd3: begin
          m_wr = (b != 32'd0);
          if (m_wr) begin
            if (op == 3'd2) begin
              q = longint'(int'(a)) / longint'(int'(b));
              r = longint'(int'(a)) % longint'(int'(b));
            end else begin
              q = longint'(64'(a) / 64'(b));
              r = longint'(64'(a) % 64'(b));
            end
            m_pl = q[31:0]; m_ph = r[31:0];
          end
          m_done_at = m_cycle + DC;
        end
        3'd4: m_hi = a;
        3'd5: m_lo = a;
        default: ;
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      check("busy", 32'(Busy), 32'(m_cycle < m_done_at));
      check("hi", HI, m_hi);
      check("lo", LO, m_lo);
    end
  end

  task automatic step(bit st, logic [2:0] op, logic [31:0] a, logic [31:0] b);
    Start = st; MDOp = op; A = a; B = b;
    @(posedge clk);
    if (!reset) model_edge(st, op, a, b);
    #1;
  endtask

  task automatic run_op(string name, logic [2:0] op, logic [31:0] a, logic [31:0] b, int n);
    int cnt;
    step(1'b1, op, a, b);
    cnt = 0;
    while (Busy && cnt < 40) begin
      step(1'b0, 3'd7, $urandom, $urandom);
      cnt++;
    end
    check({name, "_busy_cycles"}, 32'(cnt), 32'(n));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cnt;
    reset = 1'b1; Start = 1'b0; MDOp = 3'd7; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    reset = 1'b0;
    mon_on = 1'b1;

    run_op("mult", 3'd0, 32'hFFFFFFFE, 32'd3, MC);
    check("mult_hi", HI, 32'hFFFFFFFF);
    check("mult_lo", LO, 32'hFFFFFFFA);

    run_op("multu", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, MC);
    check("multu_hi", HI, 32'hFFFFFFFE);
    check("multu_lo", LO, 32'h00000001);

    run_op("div", 3'd2, 32'hFFFFFFF9, 32'd2, DC);
    check("div_lo", LO, 32'hFFFFFFFD);
    check("div_hi", HI, 32'hFFFFFFFF);

    run_op("divu", 3'd3, 32'hFFFFFFF9, 32'd2, DC);
    check("divu_lo", LO, 32'h7FFFFFFC);
    check("divu_hi", HI, 32'h00000001);

    step(1'b1, 3'd5, 32'h1234, 32'd0);
    check("mtlo_busy", 32'(Busy), 32'd0);
    check("mtlo_lo", LO, 32'h1234);
    run_op("div0", 3'd2, 32'd5, 32'd0, DC);
    check("div0_lo", LO, 32'h1234);
    check("div0_hi", HI, 32'h00000001);

    run_op("divovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, DC);
    check("divovf_lo", LO, 32'h80000000);
    check("divovf_hi", HI, 32'h0);

    // A DIV issued while the MULT is in flight must be dropped entirely.
    step(1'b1, 3'd0, 32'd7, 32'd6);
    step(1'b0, 3'd7, 32'd0, 32'd0);
    step(1'b1, 3'd2, 32'd100, 32'd3);
    cnt = 2;
    while (Busy && cnt < 40) begin
      step(1'b0, 3'd7, 32'd0, 32'd0);
      cnt++;
    end
    check("ignore_busy_cycles", 32'(cnt), 32'(MC));
    repeat (12) step(1'b0, 3'd7, 32'd0, 32'd0);
    check("ignore_lo", LO, 32'd42);
    check("ignore_hi", HI, 32'd0);
    check("ignore_idle", 32'(Busy), 32'd0);

    // Reset landing mid-operation, between clock edges.
    step(1'b1, 3'd3, 32'd100, 32'd7);
    repeat (3) step(1'b0, 3'd7, 32'd0, 32'd0);
    #2;
    reset = 1'b1;
    m_hi = '0; m_lo = '0; m_wr = 1'b0; m_done_at = m_cycle;
    #1;
    check("async_busy", 32'(Busy), 32'd0);
    check("async_hi", HI, 32'd0);
    check("async_lo", LO, 32'd0);
    step(1'b0, 3'd7, 32'd0, 32'd0);
    reset = 1'b0;
    repeat (15) step(1'b0, 3'd7, 32'd0, 32'd0);
    check("postrst_hi", HI, 32'd0);
    check("postrst_lo", LO, 32'd0);

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), pick(), pick());
    end
    repeat (DC + 2) step(1'b0, 3'd7, 32'd0, 32'd0);

    mon_on = 1'b0;
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
